// File: rtl/spi_arb_pkg.sv
// Shared constants for the SPI arbiter: sequencer state encoding and controller word width.
package spi_arb_pkg;

    localparam int SPI_DATA_W = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant. The search starts at ptr and wraps at N-1 to 0.
// An accepted grant moves ptr to the slot after the winner.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] i_req,
    input  logic         i_grant_en,
    output logic [N-1:0] o_grant
);

    localparam int PW = $clog2(N);
    localparam int SW = PW + 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_win_idx;
    logic [PW-1:0] w_pos;
    logic [SW-1:0] w_sum;
    logic          w_found;

    // The sum is one bit wider than ptr, so a single subtract handles the wrap for any N.
    always_comb begin
        o_grant   = '0;
        w_win_idx = '0;
        w_found   = 1'b0;
        w_sum     = '0;
        w_pos     = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, r_ptr} + SW'(k);
            if (w_sum >= SW'(N)) begin
                w_sum = w_sum - SW'(N);
            end
            w_pos = w_sum[PW-1:0];
            if (!w_found && i_req[w_pos]) begin
                w_found        = 1'b1;
                o_grant[w_pos] = 1'b1;
                w_win_idx      = w_pos;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_grant_en && w_found) begin
            r_ptr <= (w_win_idx == PW'(N - 1)) ? '0 : w_win_idx + PW'(1);
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one 16-bit SPI master among N_REQ requesters. It arbitrates round-robin,
// sequences start/wait/ack, enforces the inter-transfer gap and runs a wait watchdog.
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 512
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [SPI_DATA_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]            ack,
    output logic [SPI_DATA_W-1:0]       rsp_data,
    output logic                        err,
    output logic [N_REQ-1:0]            sel,
    output logic                        spi_start,
    output logic [SPI_DATA_W-1:0]       spi_data_in,
    input  logic                        spi_busy,
    input  logic [SPI_DATA_W-1:0]       spi_data_out,
    input  logic                        spi_new_data,
    output logic [2:0]                  dbg_state
);

    localparam int         WD_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES);

    // Requester handshake: req is a level held with stable req_data until that
    // requester's one-cycle ack; rsp_data and err are meaningful only in the ack cycle.
    logic [2:0]            r_state;
    logic [N_REQ-1:0]      r_sel;
    logic [SPI_DATA_W-1:0] r_tx;
    logic [SPI_DATA_W-1:0] r_rsp;
    logic                  r_err;
    logic [3:0]            r_gap;
    logic [WD_W-1:0]       r_wd;

    logic                  w_grant_en;
    logic [N_REQ-1:0]      w_grant;
    logic [SPI_DATA_W-1:0] w_wdata;
    logic                  w_wd_expire;

    assign w_grant_en = (r_state == ST_IDLE) && (|req) && !spi_busy;

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr_arbiter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req      (req),
        .i_grant_en (w_grant_en),
        .o_grant    (w_grant)
    );

    always_comb begin
        w_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_wdata = w_wdata | req_data[i*SPI_DATA_W +: SPI_DATA_W];
            end
        end
    end

    // The count is cleared in START, so expiry on the TIMEOUT-th WAIT cycle puts the
    // error ack TIMEOUT+1 cycles after spi_start.
    assign w_wd_expire = (TIMEOUT > 0) && ((32'(r_wd) + 32'd1) >= 32'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_tx    <= '0;
            r_rsp   <= '0;
            r_err   <= 1'b0;
            r_gap   <= '0;
            r_wd    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_en) begin
                        r_sel   <= w_grant;
                        r_tx    <= w_wdata;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    r_wd    <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (spi_new_data) begin
                        r_rsp   <= spi_data_out;
                        r_err   <= 1'b0;
                        r_state <= ST_DONE;
                    end else if (w_wd_expire) begin
                        r_rsp   <= '0;
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (32'(r_wd) < 32'(TIMEOUT)) begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                ST_DONE: begin
                    r_sel   <= '0;
                    r_gap   <= '0;
                    r_state <= ST_GAP;
                end
                ST_GAP: begin
                    // An aborted transfer may leave the controller busy well past the gap.
                    if ((r_gap >= GAP_LAST) && !spi_busy) begin
                        r_state <= ST_IDLE;
                    end else if (r_gap < GAP_LAST) begin
                        r_gap <= r_gap + 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack         = (r_state == ST_DONE) ? r_sel : '0;
    assign rsp_data    = (r_state == ST_DONE) ? r_rsp : '0;
    assign err         = (r_state == ST_DONE) && r_err;
    assign sel         = r_sel;
    assign spi_start   = (r_state == ST_START);
    assign spi_data_in = r_tx;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: a behavioural SPI controller, a round-robin reference
// and an expected-ack queue, driven by directed scenarios and a randomized phase.
module tb_spi_arbiter;

    localparam int N     = 4;
    localparam int GAP   = 2;
    localparam int TMO   = 20;
    localparam int EXP_W = 52;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req;
    logic [16*N-1:0] req_data;
    logic [N-1:0]    ack;
    logic [15:0]     rsp_data;
    logic            err;
    logic [N-1:0]    sel;
    logic            spi_start;
    logic [15:0]     spi_data_in;
    logic            spi_busy;
    logic [15:0]     spi_data_out;
    logic            spi_new_data;
    logic [2:0]      dbg_state;

    spi_arbiter #(
        .N_REQ      (N),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_data     (req_data),
        .ack          (ack),
        .rsp_data     (rsp_data),
        .err          (err),
        .sel          (sel),
        .spi_start    (spi_start),
        .spi_data_in  (spi_data_in),
        .spi_busy     (spi_busy),
        .spi_data_out (spi_data_out),
        .spi_new_data (spi_new_data),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_acks   = 0;
    int n_starts = 0;

    // Expected ack entry: {ack cycle[31:0], err, owner[2:0], rsp[15:0]}
    logic [EXP_W-1:0] exp_q[$];
    int               grant_log[$];

    int          m_ptr = 0;
    int          own = 0;
    bit          own_valid = 1'b0;
    int          last_ack_cyc = -1;
    int          last_start_cyc = 0;
    bit          tight_gap = 1'b0;
    bit          rand_mode = 1'b0;
    bit          hold_all = 1'b0;
    bit          k_hang = 1'b0;
    int          k_lat = 4;
    int          k_hold = 30;
    logic [15:0] k_rsp = 16'h0;
    bit          k_rsp_fixed = 1'b0;
    int          ctl_rem = 0;
    bit          ctl_hang = 1'b0;
    logic [15:0] ctl_data = 16'h0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Reference round robin: first requester at or after ptr, wrapping.
    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic int pick_lat();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return TMO;
        if (r == 1) return $urandom_range(TMO + 1, TMO + 6);
        return $urandom_range(1, 12);
    endfunction

    task automatic on_start();
        int          w;
        int          lat;
        bit          hang;
        logic [15:0] data;
        n_starts++;
        check("start_ctl_idle", spi_busy, 1'b0);
        check("start_while_owned", own_valid, 1'b0);
        check("start_req_any", |req, 1'b1);
        if (last_ack_cyc >= 0) begin
            if (tight_gap) check("gap_exact", cyc - last_ack_cyc, 3 + GAP);
            else check("gap_min", (cyc - last_ack_cyc) >= (3 + GAP), 1'b1);
        end
        w = rr_pick(req, m_ptr);
        if (w >= 0) begin
            own            = w;
            own_valid      = 1'b1;
            m_ptr          = (w + 1) % N;
            last_start_cyc = cyc;
            grant_log.push_back(w);
            check("spi_data_in", spi_data_in, req_data[w*16 +: 16]);
            lat  = rand_mode ? pick_lat() : k_lat;
            hang = rand_mode ? 1'b0 : k_hang;
            data = k_rsp_fixed ? k_rsp : 16'($urandom);
            if (!hang && lat <= TMO) exp_q.push_back({32'(cyc + lat + 1), 1'b0, 3'(w), data});
            else exp_q.push_back({32'(cyc + TMO + 1), 1'b1, 3'(w), 16'h0000});
            spi_busy = 1'b1;
            ctl_rem  = hang ? k_hold : lat;
            ctl_hang = hang;
            ctl_data = data;
        end
    endtask

    // One clock: observe outputs at the falling edge, then advance the controller and requesters.
    task automatic tick();
        logic [EXP_W-1:0] e;
        bit               started;
        @(negedge clk);
        cyc++;
        started = rst_n && spi_start;
        if (started) on_start();
        if (own_valid) check("sel_owner", sel, onehot(own));
        else check("sel_idle", sel, '0);
        if (ack != '0) begin
            n_acks++;
            if (exp_q.size() == 0) begin
                check("ack_spurious", ack, '0);
            end else begin
                e = exp_q.pop_front();
                check("ack_cycle", cyc, e[51:20]);
                check("ack_owner", ack, onehot(int'(e[18:16])));
                check("rsp_data", rsp_data, e[15:0]);
                check("err", err, e[19]);
            end
            own_valid    = 1'b0;
            last_ack_cyc = cyc;
            if (!hold_all) req = req & ~ack;
        end else if (exp_q.size() > 0 && int'(exp_q[0][51:20]) <= cyc) begin
            check("ack_missing", ack, onehot(int'(exp_q[0][18:16])));
            void'(exp_q.pop_front());
            own_valid = 1'b0;
        end
        spi_new_data = 1'b0;
        spi_data_out = 16'($urandom);
        if (!rst_n) begin
            spi_busy = 1'b0;
            ctl_rem  = 0;
        end else if (!started && ctl_rem > 0) begin
            ctl_rem--;
            if (ctl_rem == 0) begin
                spi_busy = 1'b0;
                if (!ctl_hang) begin
                    spi_new_data = 1'b1;
                    spi_data_out = ctl_data;
                end
            end
        end
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && !(own_valid && own == i) && $urandom_range(0, 30) == 0) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    req_data[i*16 +: 16] = 16'($urandom);
                end
            end
        end
    endtask

    task automatic wait_acks(input int target, input int budget);
        int b;
        b = 0;
        while (n_acks < target && b < budget) begin
            tick();
            b++;
        end
        if (n_acks < target) check("ack_budget", n_acks, target);
    endtask

    task automatic wait_grant(input int budget);
        int b;
        b = 0;
        while (!own_valid && b < budget) begin
            tick();
            b++;
        end
        check("grant_budget", own_valid, 1'b1);
    endtask

    // Asserts reset between edges and checks the outputs clear before the next rising edge.
    task automatic apply_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_ack", ack, '0);
        check("rst_rsp_data", rsp_data, '0);
        check("rst_err", err, 1'b0);
        check("rst_sel", sel, '0);
        check("rst_spi_start", spi_start, 1'b0);
        check("rst_spi_data_in", spi_data_in, '0);
        check("rst_state", dbg_state, spi_arb_pkg::ST_IDLE);
        exp_q.delete();
        grant_log.delete();
        own_valid    = 1'b0;
        m_ptr        = 0;
        last_ack_cyc = -1;
        req          = '0;
        spi_busy     = 1'b0;
        spi_new_data = 1'b0;
        ctl_rem      = 0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};
    int n_two;
    int b;

    initial begin
        req          = '0;
        req_data     = '0;
        spi_busy     = 1'b0;
        spi_new_data = 1'b0;
        spi_data_out = '0;
        apply_reset();

        // Single requester with a fixed controller response.
        req_data[15:0] = 16'hA55A;
        k_lat          = 6;
        k_rsp          = 16'h1234;
        k_rsp_fixed    = 1'b1;
        req            = 4'b0001;
        wait_acks(n_acks + 1, 60);
        check("single_starts", n_starts, 1);
        repeat (8) tick();

        // Contention: all four held high, fast controller.
        apply_reset();
        hold_all = 1'b1;
        tight_gap = 1'b1;
        k_lat = 3;
        req_data = {16'h3333, 16'h2222, 16'h1111, 16'h0F0F};
        req = 4'b1111;
        wait_acks(n_acks + 5, 200);
        req = '0;
        hold_all = 1'b0;
        tight_gap = 1'b0;
        check("rr_count", grant_log.size(), 5);
        for (int k = 0; k < 5 && k < grant_log.size(); k++) begin
            check("rr_order", grant_log[k], exp_order[k]);
        end
        repeat (10) tick();

        // Timeout with the controller stuck busy; a second requester must wait for it.
        k_hang = 1'b1;
        k_hold = 32;
        req_data[31:16] = 16'hBEEF;
        req = 4'b0010;
        wait_grant(20);
        k_hang = 1'b0;
        tick();
        req[2] = 1'b1;
        req_data[47:32] = 16'hC0DE;
        wait_acks(n_acks + 1, 60);
        check("timeout_latency", last_ack_cyc - last_start_cyc, TMO + 1);
        wait_acks(n_acks + 1, 100);

        // Response arrives on the same edge as watchdog expiry.
        k_lat = TMO;
        k_rsp = 16'h5AA5;
        req_data[63:48] = 16'h7777;
        req = 4'b1000;
        wait_acks(n_acks + 1, 60);
        repeat (6) tick();

        // Early drop during WAIT, then reset mid-transfer.
        k_lat = 15;
        req_data[15:0] = 16'h0101;
        req = 4'b0001;
        wait_grant(20);
        tick();
        req[2] = 1'b1;
        tick();
        req[2] = 1'b0;
        tick();
        tick();
        apply_reset();
        req_data = {16'h4444, 16'h0, 16'h0, 16'h1010};
        req = 4'b1001;
        wait_acks(n_acks + 2, 150);
        n_two = 0;
        foreach (grant_log[k]) if (grant_log[k] == 2) n_two++;
        check("dropped_never_granted", n_two, 0);
        if (grant_log.size() > 0) check("post_rst_first", grant_log[0], 0);
        else check("post_rst_grants", grant_log.size(), 2);
        apply_reset();
        req = 4'b1000;
        wait_acks(n_acks + 1, 60);
        if (grant_log.size() > 0) check("req3_only_first", grant_log[0], 3);
        else check("req3_only_grants", grant_log.size(), 1);

        // Randomized traffic, then drain.
        k_rsp_fixed = 1'b0;
        rand_mode = 1'b1;
        repeat (1500) tick();
        rand_mode = 1'b0;
        b = 0;
        while ((own_valid || req != '0) && b < 400) begin
            tick();
            b++;
        end
        check("drained_req", req, '0);
        check("drained_queue", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
